// File: rtl/fb_scanout.sv
// Display-side frame buffer reader: 640x480@60 VGA timing, 4x4 pixel replication,
// incremental address generation and a latency-matched sync/blank pipeline.
module fb_scanout #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int SCALE_LOG2   = 2,
  parameter int FB_WIDTH     = 160,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        scan_en,
  output logic [14:0] pixel_addr,
  input  logic [11:0] pixel_data,
  output logic [11:0] pixel,
  output logic        h_sync,
  output logic        v_sync,
  output logic        vblank_int
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // Stages ahead of the output register: address register plus read latency.
  localparam int DL = READ_LATENCY + 1;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]  HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [14:0] ROW_STEP = 15'(FB_WIDTH);

  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic [14:0]   row_base;
  logic [7:0]    col;
  logic          h_last;
  logic          v_last;
  logic          visible;
  logic          hs_raw;
  logic          vs_raw;
  logic          vb_raw;
  logic          row_end;
  logic          col_step;
  logic [DL-1:0] vis_sr;
  logic [DL-1:0] hs_sr;
  logic [DL-1:0] vs_sr;
  logic [DL-1:0] vb_sr;

  assign h_last   = (h_cnt == H_LAST);
  assign v_last   = (v_cnt == V_LAST);
  assign visible  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_raw   = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw   = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign vb_raw   = (h_cnt == 10'd0) && (v_cnt == V_VIS);
  assign col_step = (h_cnt < H_VIS) && (&h_cnt[SCALE_LOG2-1:0]);
  // Last replicated line of a stored row: advance to the next frame buffer row.
  assign row_end  = h_last && (v_cnt < V_VIS) && (&v_cnt[SCALE_LOG2-1:0]);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      row_base   <= '0;
      col        <= '0;
      pixel_addr <= '0;
    end else begin
      if (h_last) begin
        col <= '0;
      end else if (col_step) begin
        col <= col + 8'd1;
      end
      if (h_last && v_last) begin
        row_base <= '0;
      end else if (row_end) begin
        row_base <= row_base + ROW_STEP;
      end
      // Held outside the visible area so the address never runs past the last row.
      if (visible) begin
        pixel_addr <= row_base + {7'd0, col};
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      vis_sr <= '0;
      hs_sr  <= '1;
      vs_sr  <= '1;
      vb_sr  <= '0;
    end else begin
      vis_sr <= {vis_sr[DL-2:0], visible};
      hs_sr  <= {hs_sr[DL-2:0], hs_raw};
      vs_sr  <= {vs_sr[DL-2:0], vs_raw};
      vb_sr  <= {vb_sr[DL-2:0], vb_raw};
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      pixel      <= '0;
      h_sync     <= 1'b1;
      v_sync     <= 1'b1;
      vblank_int <= 1'b0;
    end else begin
      pixel      <= (vis_sr[DL-1] && scan_en) ? pixel_data : 12'h000;
      h_sync     <= hs_sr[DL-1];
      v_sync     <= vs_sr[DL-1];
      vblank_int <= vb_sr[DL-1];
    end
  end

endmodule
